// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side handshake bundle for uart_tx_arbiter.
// The arbiter connects through the slave modport; the requesters and TX core drive master.
interface uart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    tx_busy;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_data_valid;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_data_valid
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX core among N_REQ byte requesters.
// It issues one start pulse per frame, tracks tx_busy to completion and inserts an idle gap.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16,
  localparam int IDX_W       = $clog2(N_REQ)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               arb_en,
  uart_tx_arbiter_if.slave   bus,
  output logic [IDX_W-1:0]   grant_id,
  output logic               active,
  output logic               frame_done,
  output logic               err_timeout
);

  localparam int TO_W = $clog2(BUSY_TIMEOUT);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  // With a zero gap the frame end returns straight to IDLE and drops active at once.
  localparam state_t S_POST_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
  localparam logic   ACTIVE_POST  = (GAP_CYCLES != 0);

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel_idx;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % N_REQ);
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_REQ - 1)) ? '0 : g + IDX_W'(1);
  endfunction

  // Descending scan so the last hit is the nearest valid requester at or after rr_ptr.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_idx(32'(rr_ptr) + 32'(k))]) begin
        sel_vld = 1'b1;
        sel_idx = wrap_idx(32'(rr_ptr) + 32'(k));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      to_cnt            <= '0;
      gap_cnt           <= '0;
      bus.req_ready     <= '0;
      bus.tx_data       <= '0;
      bus.tx_data_valid <= 1'b0;
      grant_id          <= '0;
      active            <= 1'b0;
      frame_done        <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      bus.req_ready     <= '0;
      bus.tx_data_valid <= 1'b0;
      frame_done        <= 1'b0;
      err_timeout       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_en && sel_vld) begin
            bus.tx_data   <= bus.req_data[sel_idx*DATA_W +: DATA_W];
            grant_id      <= sel_idx;
            bus.req_ready <= N_REQ'(1) << sel_idx;
            active        <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.tx_data_valid <= 1'b1;
          to_cnt            <= '0;
          state             <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            rr_ptr      <= next_ptr(grant_id);
            gap_cnt     <= '0;
            active      <= ACTIVE_POST;
            state       <= S_POST_FRAME;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            frame_done <= 1'b1;
            rr_ptr     <= next_ptr(grant_id);
            gap_cnt    <= '0;
            active     <= ACTIVE_POST;
            state      <= S_POST_FRAME;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            active <= 1'b0;
            state  <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default build (gap 2, timeout 16) plus a zero-gap build.
module tb_uart_tx_arbiter;

  logic CLK = 1'b0;
  logic RST;
  logic arb_en_a, arb_en_b;
  logic [1:0] gid_a, gid_b;
  logic act_a, act_b, fd_a, fd_b, to_a, to_b;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) ifa ();
  uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) ifb ();

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYCLES(2), .BUSY_TIMEOUT(16)) dut_a (
    .CLK(CLK), .RST(RST), .arb_en(arb_en_a), .bus(ifa.slave),
    .grant_id(gid_a), .active(act_a), .frame_done(fd_a), .err_timeout(to_a)
  );

  uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .BUSY_TIMEOUT(16)) dut_b (
    .CLK(CLK), .RST(RST), .arb_en(arb_en_b), .bus(ifb.slave),
    .grant_id(gid_b), .active(act_b), .frame_done(fd_b), .err_timeout(to_b)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts right after the accept edge; busy rises one cycle after the start pulse.
  task automatic finish_frame();
    tick();
    chk("ff_data_valid", 32'(ifa.tx_data_valid), 1);
    ifa.tx_busy = 1'b0;
    tick();
    ifa.tx_busy = 1'b1;
    tick();
    tick();
    ifa.tx_busy = 1'b0;
    tick();
    chk("ff_frame_done", 32'(fd_a), 1);
    tick();
    tick();
    chk("ff_active_low", 32'(act_a), 0);
  endtask

  task automatic run_frame(input int id, input logic [7:0] d);
    tick();
    chk("rr_ready", 32'(ifa.req_ready), 32'(1) << id);
    chk("rr_grant", 32'(gid_a), id);
    chk("rr_data", 32'(ifa.tx_data), 32'(d));
    finish_frame();
  endtask

  initial begin
    RST = 1'b1;
    arb_en_a = 1'b0;
    arb_en_b = 1'b0;
    ifa.req_valid = '0;
    ifb.req_valid = '0;
    ifa.req_data = {8'h3C, 8'hA5, 8'h5A, 8'h0F};
    ifb.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    ifa.tx_busy = 1'b0;
    ifb.tx_busy = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(ifa.req_ready), 0);
    chk("rst_dv", 32'(ifa.tx_data_valid), 0);
    chk("rst_gid", 32'(gid_a), 0);
    chk("rst_active", 32'(act_a), 0);
    chk("rst_fd", 32'(fd_a), 0);
    chk("rst_to", 32'(to_a), 0);
    chk("rst_data", 32'(ifa.tx_data), 0);
    RST = 1'b0;

    // Single request from requester 2
    ifa.req_valid = 4'b0100;
    arb_en_a = 1'b1;
    tick();
    chk("t1_ready", 32'(ifa.req_ready), 4);
    chk("t1_gid", 32'(gid_a), 2);
    chk("t1_data", 32'(ifa.tx_data), 32'h A5);
    chk("t1_active", 32'(act_a), 1);
    chk("t1_dv_early", 32'(ifa.tx_data_valid), 0);
    ifa.req_valid = '0;
    tick();
    chk("t1_dv", 32'(ifa.tx_data_valid), 1);
    chk("t1_ready_clr", 32'(ifa.req_ready), 0);
    tick();
    ifa.tx_busy = 1'b1;
    chk("t1_dv_clr", 32'(ifa.tx_data_valid), 0);
    repeat (11) tick();
    chk("t1_fd_busy", 32'(fd_a), 0);
    chk("t1_act_busy", 32'(act_a), 1);
    ifa.tx_busy = 1'b0;
    tick();
    chk("t1_fd", 32'(fd_a), 1);
    chk("t1_to", 32'(to_a), 0);
    chk("t1_act_fd", 32'(act_a), 1);
    tick();
    chk("t1_fd_clr", 32'(fd_a), 0);
    chk("t1_act_gap", 32'(act_a), 1);
    tick();
    chk("t1_act_low", 32'(act_a), 0);
    chk("t1_gid_hold", 32'(gid_a), 2);
    chk("t1_data_hold", 32'(ifa.tx_data), 32'h A5);

    // Round robin with all requesters valid, pointer starts at 3
    ifa.req_valid = 4'hF;
    run_frame(3, 8'h3C);
    run_frame(0, 8'h0F);
    run_frame(1, 8'h5A);
    run_frame(2, 8'hA5);
    run_frame(3, 8'h3C);

    // Busy never rises
    ifa.req_valid = 4'b0010;
    tick();
    chk("to_ready", 32'(ifa.req_ready), 2);
    chk("to_gid", 32'(gid_a), 1);
    ifa.req_valid = '0;
    tick();
    chk("to_dv", 32'(ifa.tx_data_valid), 1);
    repeat (15) tick();
    chk("to_early", 32'(to_a), 0);
    tick();
    chk("to_pulse", 32'(to_a), 1);
    chk("to_no_fd", 32'(fd_a), 0);
    ifa.req_valid = 4'b0110;
    tick();
    chk("to_clr", 32'(to_a), 0);
    tick();
    chk("to_act_low", 32'(act_a), 0);
    tick();
    chk("to_next_ready", 32'(ifa.req_ready), 4);
    chk("to_next_gid", 32'(gid_a), 2);

    // arb_en dropped during WAIT_DONE with requester 1 pending
    ifa.req_valid = 4'b0010;
    tick();
    chk("en_dv", 32'(ifa.tx_data_valid), 1);
    tick();
    ifa.tx_busy = 1'b1;
    tick();
    arb_en_a = 1'b0;
    tick();
    ifa.tx_busy = 1'b0;
    tick();
    chk("en_fd", 32'(fd_a), 1);
    tick();
    tick();
    chk("en_act_low", 32'(act_a), 0);
    repeat (3) begin
      tick();
      chk("en_hold_ready", 32'(ifa.req_ready), 0);
    end
    arb_en_a = 1'b1;
    tick();
    chk("en_ready", 32'(ifa.req_ready), 2);
    chk("en_gid", 32'(gid_a), 1);

    // Reset in WAIT_DONE
    ifa.req_valid = 4'b1001;
    tick();
    chk("rm_dv", 32'(ifa.tx_data_valid), 1);
    tick();
    ifa.tx_busy = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rm_ready", 32'(ifa.req_ready), 0);
    chk("rm_dv0", 32'(ifa.tx_data_valid), 0);
    chk("rm_gid", 32'(gid_a), 0);
    chk("rm_active", 32'(act_a), 0);
    chk("rm_fd", 32'(fd_a), 0);
    chk("rm_to", 32'(to_a), 0);
    chk("rm_data", 32'(ifa.tx_data), 0);
    tick();
    chk("rm_acc_ready", 32'(ifa.req_ready), 1);
    chk("rm_acc_gid", 32'(gid_a), 0);
    chk("rm_acc_data", 32'(ifa.tx_data), 32'h0F);
    finish_frame();
    tick();
    chk("rm_r3_ready", 32'(ifa.req_ready), 8);
    chk("rm_r3_gid", 32'(gid_a), 3);
    chk("rm_r3_data", 32'(ifa.tx_data), 32'h3C);
    ifa.req_valid = '0;

    // Zero-gap build, back-to-back requests
    ifb.req_valid = 4'b0011;
    arb_en_b = 1'b1;
    tick();
    chk("g0_ready0", 32'(ifb.req_ready), 1);
    chk("g0_gid0", 32'(gid_b), 0);
    tick();
    chk("g0_dv", 32'(ifb.tx_data_valid), 1);
    tick();
    ifb.tx_busy = 1'b1;
    tick();
    ifb.tx_busy = 1'b0;
    tick();
    chk("g0_fd", 32'(fd_b), 1);
    chk("g0_act", 32'(act_b), 0);
    chk("g0_ready_fd", 32'(ifb.req_ready), 0);
    tick();
    chk("g0_ready1", 32'(ifb.req_ready), 2);
    chk("g0_gid1", 32'(gid_b), 1);
    chk("g0_data1", 32'(ifb.tx_data), 32'h22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
